// File: rtl/color_region_manager.sv
// Region colour mapper: splits the active area into a rows x cols grid and outputs the colour of the region under the pixel counters.
// Optional CRM_DEBUG_PATTERN_EN: VGA_Debugg=1 outputs the region index pattern instead of the stored colour.
module color_region_manager #(
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 11,
  parameter int C_ADDR_WIDTH  = 8,
  parameter int C_DATA_WIDTH  = 16,
  parameter int MAX_COLS      = 4,
  parameter int MAX_ROWS      = 4,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_RES   = 8'h10,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_GRID  = 8'h11,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_COLOR = 8'h12
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [C_ADDR_WIDTH-1:0]  C_Addr,
  input  logic [C_DATA_WIDTH-1:0]  C_Data,
  input  logic                     C_Valid,
  output logic                     C_Rdy,
  input  logic                     VGA_Debugg,
  input  logic                     Counter_X_Valid,
  input  logic                     Counter_Y_Valid,
  input  logic [COUNTER_WIDTH-1:0] Counter_X,
  input  logic [COUNTER_WIDTH-1:0] Counter_Y,
  output logic [DATA_WIDTH-1:0]    Data_VGA,
  output logic [COUNTER_WIDTH-1:0] H_Active,
  output logic [COUNTER_WIDTH-1:0] V_Active,
  output logic [7:0]               VGA_Notification,
  output logic                     VGA_Notification_Valid,
  output logic [1:0]               fsm_state
);
  localparam int CW = COUNTER_WIDTH;
  localparam logic [4:0] MAX_C  = 5'(MAX_COLS);
  localparam logic [4:0] MAX_R  = 5'(MAX_ROWS);
  localparam logic [4:0] NREG_L = 5'(MAX_COLS * MAX_ROWS);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV_X = 2'd1, DIV_Y = 2'd2, COMMIT = 2'd3} state_t;
  state_t state, state_next;

  // Committed geometry, used by the pixel path until COMMIT swaps in the pending set.
  logic [CW-1:0] h_act, v_act, step_x, step_y;
  logic [4:0]    rows_r, cols_r;
  logic [CW-1:0] pend_h, pend_v, rem, quot, new_step_x;
  logic [4:0]    pend_rows, pend_cols;
  logic          color_hold;
  logic [DATA_WIDTH-1:0] colors [16];
  logic [DATA_WIDTH-1:0] data_vga, pix_color;
  logic [7:0]    notif;
  logic          notif_v;

  logic          wr_acc, is_color, res_ok, grid_ok, start, div_ge;
  logic [4:0]    rows_in, cols_in;
  logic [CW-1:0] res_h, res_v;
  logic [CW+3:0] acc_x, acc_y;
  logic [3:0]    col_idx, row_idx, region;

  // Handshake: a write transfers on a rising edge where C_Valid==0 and C_Rdy==1; otherwise it is dropped.
  assign C_Rdy    = (state == IDLE) && !color_hold;
  assign wr_acc   = !C_Valid && C_Rdy;
  assign rows_in  = {1'b0, C_Data[7:4]} + 5'd1;
  assign cols_in  = {1'b0, C_Data[3:0]} + 5'd1;
  assign is_color = (C_Addr == ADDR_COLOR);
  assign res_ok   = (C_Addr == ADDR_RES) && (C_Data[1:0] != 2'd3);
  assign grid_ok  = (C_Addr == ADDR_GRID) && (rows_in <= MAX_R) && (cols_in <= MAX_C);
  assign start    = wr_acc && (res_ok || grid_ok);
  assign div_ge   = (state == DIV_X) ? (rem >= CW'(pend_cols)) : (rem >= CW'(pend_rows));

  always_comb begin
    res_h = CW'(640);
    res_v = CW'(480);
    case (C_Data[1:0])
      2'd1:    begin res_h = CW'(800);  res_v = CW'(600); end
      2'd2:    begin res_h = CW'(1024); res_v = CW'(768); end
      default: begin res_h = CW'(640);  res_v = CW'(480); end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIV_X;
      DIV_X:   if (!div_ge) state_next = DIV_Y;
      DIV_Y:   if (!div_ge) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Column/row = number of step multiples not exceeding the counter, capped by the grid size.
  always_comb begin
    acc_x   = '0;
    acc_y   = '0;
    col_idx = '0;
    row_idx = '0;
    for (int k = 1; k < MAX_COLS; k++) begin
      acc_x = acc_x + {4'b0, step_x};
      if ((5'(k) < cols_r) && ({4'b0, Counter_X} >= acc_x)) col_idx = col_idx + 4'd1;
    end
    for (int k = 1; k < MAX_ROWS; k++) begin
      acc_y = acc_y + {4'b0, step_y};
      if ((5'(k) < rows_r) && ({4'b0, Counter_Y} >= acc_y)) row_idx = row_idx + 4'd1;
    end
    region = row_idx * cols_r[3:0] + col_idx;
  end

`ifdef CRM_DEBUG_PATTERN_EN
  logic [DATA_WIDTH-1:0] dbg_pattern;
  always_comb begin
    dbg_pattern = '0;
    for (int i = 0; i < DATA_WIDTH; i++) dbg_pattern[i] = region[2'(i % 4)];
    pix_color = VGA_Debugg ? dbg_pattern : colors[region];
  end
`else
  logic unused_debugg;
  assign unused_debugg = VGA_Debugg;
  assign pix_color     = colors[region];
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      h_act      <= CW'(640);
      v_act      <= CW'(480);
      step_x     <= CW'(640);
      step_y     <= CW'(480);
      rows_r     <= 5'd1;
      cols_r     <= 5'd1;
      pend_h     <= '0;
      pend_v     <= '0;
      pend_rows  <= 5'd1;
      pend_cols  <= 5'd1;
      rem        <= '0;
      quot       <= '0;
      new_step_x <= '0;
      color_hold <= 1'b0;
      notif      <= 8'h00;
      notif_v    <= 1'b0;
      data_vga   <= '0;
      for (int i = 0; i < 16; i++) colors[i] <= '0;
    end else begin
      notif_v    <= 1'b0;
      color_hold <= wr_acc && is_color;
      if (wr_acc && is_color && ({1'b0, C_Data[C_DATA_WIDTH-1 -: 4]} < NREG_L))
        colors[C_Data[C_DATA_WIDTH-1 -: 4]] <= C_Data[DATA_WIDTH-1:0];
      case (state)
        IDLE: if (start) begin
          quot <= '0;
          if (res_ok) begin
            pend_h    <= res_h;
            pend_v    <= res_v;
            pend_rows <= rows_r;
            pend_cols <= cols_r;
            rem       <= res_h;
          end else begin
            pend_h    <= h_act;
            pend_v    <= v_act;
            pend_rows <= rows_in;
            pend_cols <= cols_in;
            rem       <= h_act;
          end
        end
        DIV_X: if (div_ge) begin
          rem  <= rem - CW'(pend_cols);
          quot <= quot + CW'(1);
        end else begin
          new_step_x <= quot;
          rem        <= pend_v;
          quot       <= '0;
        end
        DIV_Y: if (div_ge) begin
          rem  <= rem - CW'(pend_rows);
          quot <= quot + CW'(1);
        end
        COMMIT: begin
          h_act   <= pend_h;
          v_act   <= pend_v;
          step_x  <= new_step_x;
          step_y  <= quot;
          rows_r  <= pend_rows;
          cols_r  <= pend_cols;
          notif   <= {pend_rows[3:0] - 4'd1, pend_cols[3:0] - 4'd1};
          notif_v <= 1'b1;
        end
        default: ;
      endcase
      data_vga <= (Counter_X_Valid && Counter_Y_Valid) ? pix_color : '0;
    end
  end

  assign Data_VGA               = data_vga;
  assign H_Active               = h_act;
  assign V_Active               = v_act;
  assign VGA_Notification       = notif;
  assign VGA_Notification_Valid = notif_v;
  assign fsm_state              = state;
endmodule

// File: tb/tb_color_region_manager.sv
// Directed bench for color_region_manager: reset, colour/grid/resolution writes, mapping boundaries, reset abort.
module tb_color_region_manager;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  C_Addr;
  logic [15:0] C_Data;
  logic        C_Valid;
  logic        C_Rdy;
  logic        VGA_Debugg;
  logic        Counter_X_Valid, Counter_Y_Valid;
  logic [10:0] Counter_X, Counter_Y;
  logic [11:0] Data_VGA;
  logic [10:0] H_Active, V_Active;
  logic [7:0]  VGA_Notification;
  logic        VGA_Notification_Valid;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  color_region_manager dut (
    .Clk(Clk), .Rst(Rst), .C_Addr(C_Addr), .C_Data(C_Data), .C_Valid(C_Valid),
    .C_Rdy(C_Rdy), .VGA_Debugg(VGA_Debugg),
    .Counter_X_Valid(Counter_X_Valid), .Counter_Y_Valid(Counter_Y_Valid),
    .Counter_X(Counter_X), .Counter_Y(Counter_Y), .Data_VGA(Data_VGA),
    .H_Active(H_Active), .V_Active(V_Active), .VGA_Notification(VGA_Notification),
    .VGA_Notification_Valid(VGA_Notification_Valid), .fsm_state(fsm_state)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [15:0] data);
    @(negedge Clk);
    C_Addr  = addr;
    C_Data  = data;
    C_Valid = 1'b0;
    @(negedge Clk);
    C_Valid = 1'b1;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic xv,
                     input logic yv, input logic [11:0] exp);
    @(negedge Clk);
    Counter_X       = 11'(x);
    Counter_Y       = 11'(y);
    Counter_X_Valid = xv;
    Counter_Y_Valid = yv;
    @(negedge Clk);
    check(tag, 32'(Data_VGA), 32'(exp));
  endtask

  task automatic wait_notif(input string tag, input logic [7:0] exp_notif);
    int   cyc;
    logic seen, rdy_low;
    cyc     = 0;
    seen    = 1'b0;
    rdy_low = !C_Rdy;
    while (!seen && cyc < 3000) begin
      @(negedge Clk);
      cyc++;
      if (VGA_Notification_Valid) seen = 1'b1;
      else if (C_Rdy) rdy_low = 1'b0;
    end
    check({tag, " notif seen"}, 32'(seen), 32'd1);
    check({tag, " rdy low in recompute"}, 32'(rdy_low), 32'd1);
    if (seen) begin
      check({tag, " notif value"}, 32'(VGA_Notification), 32'(exp_notif));
      check({tag, " rdy back"}, 32'(C_Rdy), 32'd1);
      @(negedge Clk);
      check({tag, " notif pulse width"}, 32'(VGA_Notification_Valid), 32'd0);
    end
  endtask

  task automatic no_notif(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (VGA_Notification_Valid) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; C_Addr = '0; C_Data = '0; C_Valid = 1'b1; VGA_Debugg = 1'b0;
    Counter_X_Valid = 1'b0; Counter_Y_Valid = 1'b0; Counter_X = '0; Counter_Y = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;

    // Reset state
    check("rst c_rdy", 32'(C_Rdy), 32'd1);
    check("rst h_active", 32'(H_Active), 32'd640);
    check("rst v_active", 32'(V_Active), 32'd480);
    check("rst notif", 32'(VGA_Notification), 32'h00);
    check("rst notif valid", 32'(VGA_Notification_Valid), 32'd0);
    check("rst fsm", 32'(fsm_state), 32'd0);
    pix("rst pixel 100,100", 100, 100, 1'b1, 1'b1, 12'h000);

    // Colour writes; C_Rdy drops for exactly one cycle after each
    cfg_write(8'h12, {4'd0, 12'hF00});
    check("color rdy low", 32'(C_Rdy), 32'd0);
    @(negedge Clk);
    check("color rdy back", 32'(C_Rdy), 32'd1);
    cfg_write(8'h12, {4'd1, 12'h0F0});
    cfg_write(8'h12, {4'd2, 12'h00F});
    cfg_write(8'h12, {4'd3, 12'hFFF});
    pix("1x1 pixel 639,479", 639, 479, 1'b1, 1'b1, 12'hF00);

    // 2x2 grid at 640x480: step 320 x 240
    cfg_write(8'h11, 16'h0011);
    check("grid fsm div_x", 32'(fsm_state), 32'd1);
    wait_notif("grid 2x2", 8'h11);
    pix("2x2 319,239", 319, 239, 1'b1, 1'b1, 12'hF00);
    pix("2x2 320,239", 320, 239, 1'b1, 1'b1, 12'h0F0);
    pix("2x2 320,240", 320, 240, 1'b1, 1'b1, 12'hFFF);
    pix("2x2 0,479", 0, 479, 1'b1, 1'b1, 12'h00F);

    // 3x1 grid at 640x480: step_x 213
    cfg_write(8'h11, 16'h0002);
    wait_notif("grid 3x1", 8'h02);
    pix("3x1 212,0", 212, 0, 1'b1, 1'b1, 12'hF00);
    pix("3x1 213,0", 213, 0, 1'b1, 1'b1, 12'h0F0);
    pix("3x1 639,0", 639, 0, 1'b1, 1'b1, 12'h00F);

    // 800x600 with 3x1: old geometry in use during recompute, colour write dropped
    cfg_write(8'h10, 16'h0001);
    check("res rdy low", 32'(C_Rdy), 32'd0);
    pix("recompute old geom 320,240", 320, 240, 1'b1, 1'b1, 12'h0F0);
    check("recompute h_active old", 32'(H_Active), 32'd640);
    cfg_write(8'h12, {4'd0, 12'h123});
    wait_notif("res 800", 8'h02);
    check("res h_active", 32'(H_Active), 32'd800);
    check("res v_active", 32'(V_Active), 32'd600);
    pix("800 265,0", 265, 0, 1'b1, 1'b1, 12'hF00);
    pix("800 266,0", 266, 0, 1'b1, 1'b1, 12'h0F0);
    pix("800 532,0", 532, 0, 1'b1, 1'b1, 12'h00F);
    pix("800 799,0 last col", 799, 0, 1'b1, 1'b1, 12'h00F);
    pix("dropped color write", 0, 0, 1'b1, 1'b1, 12'hF00);

    // Invalid grid and resolution code 3 are ignored
    cfg_write(8'h11, 16'h0055);
    check("bad grid rdy", 32'(C_Rdy), 32'd1);
    check("bad grid fsm", 32'(fsm_state), 32'd0);
    no_notif("bad grid no notif", 20);
    cfg_write(8'h10, 16'h0003);
    check("res 3 rdy", 32'(C_Rdy), 32'd1);
    no_notif("res 3 no notif", 20);
    check("res 3 h_active", 32'(H_Active), 32'd800);

    // Counter valid blanking
    pix("x invalid", 10, 10, 1'b0, 1'b1, 12'h000);
    pix("y invalid", 10, 10, 1'b1, 1'b0, 12'h000);

    // Same-cycle write and lookup of region 0
    @(negedge Clk);
    Counter_X = 11'd0; Counter_Y = 11'd0; Counter_X_Valid = 1'b1; Counter_Y_Valid = 1'b1;
    C_Addr = 8'h12; C_Data = {4'd0, 12'h456}; C_Valid = 1'b0;
    @(negedge Clk);
    C_Valid = 1'b1;
    check("same cycle old color", 32'(Data_VGA), 32'hF00);
    @(negedge Clk);
    check("next lookup new color", 32'(Data_VGA), 32'h456);

    // Reset during DIV_X aborts the recompute
    cfg_write(8'h11, 16'h0011);
    check("abort fsm div_x", 32'(fsm_state), 32'd1);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    check("abort fsm idle", 32'(fsm_state), 32'd0);
    check("abort h_active", 32'(H_Active), 32'd640);
    check("abort v_active", 32'(V_Active), 32'd480);
    check("abort notif", 32'(VGA_Notification), 32'h00);
    check("abort c_rdy", 32'(C_Rdy), 32'd1);
    no_notif("abort no notif", 1200);
    pix("abort colors cleared", 0, 0, 1'b1, 1'b1, 12'h000);
    cfg_write(8'h12, {4'd0, 12'h777});
    pix("abort 1x1 grid 639,479", 639, 479, 1'b1, 1'b1, 12'h777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
